dense_to_coo_packer: RTL and testbench

DENSE_TO_COO_PACKER -- requirements
Module: dense_to_coo_packer

---
 rtl/coo_pkg.sv | 19 +
 rtl/coo_prio_enc.sv | 20 ++
 rtl/dense_to_coo_packer.sv | 133 +++++++++++++
 tb/tb_dense_to_coo_packer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coo_pkg.sv
// Shared COO types and sizing, used by dense_to_coo_packer and sparse_coo_matmul.
package coo_pkg;
  localparam int N       = 8;
  localparam int MAX_NNZ = 32;

  typedef logic [7:0] fp8_t;
  typedef logic [2:0] idx_t;

  typedef struct packed {
    fp8_t data;
    idx_t row;
    idx_t col;
  } coo_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/coo_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set request bit and an any-set flag.
module coo_prio_enc #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = W - 1; i >= 0; i--) begin
      idx = req[i] ? IW'(i) : idx;
    end
  end

endmodule

// File: rtl/dense_to_coo_packer.sv
// Dense FP8 row beats -> COO entries, nonzeros emitted lowest column first, one per cycle.
// Optional macro COO_DENORM_FLUSH_EN: E4M3 denormals (exponent bits == 0) are also treated as zero.
module dense_to_coo_packer
  import coo_pkg::*;
#(
  parameter int N       = coo_pkg::N,
  parameter int MAX_NNZ = coo_pkg::MAX_NNZ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0][7:0] in_row,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output fp8_t              out_data,
  output idx_t              out_row,
  output idx_t              out_col,
  output logic [5:0]        nnz,
  output logic              overflow,
  output logic              mat_done
);

  function automatic logic is_nonzero(input fp8_t e);
`ifdef COO_DENORM_FLUSH_EN
    return e[6:3] != 4'd0;
`else
    return e[6:0] != 7'd0;
`endif
  endfunction

  state_t            state_r, state_s;
  logic              ready_r;
  logic [N-1:0]      mask_r, mask_next_s, nz_s;
  logic [N-1:0][7:0] row_r;
  idx_t              cur_row_r, row_cnt_r, row_idx_s;
  logic              last_r, new_mat_r;
  logic [5:0]        nnz_r;
  logic              ovf_r;
  idx_t              sel_s;
  logic              any_s, full_s, valid_s, hs_s, leave_s, accept_s;
  coo_entry_t        ent_s;

  coo_prio_enc #(.W(N)) u_enc (
    .req (mask_r),
    .idx (sel_s),
    .any (any_s)
  );

  // nonzero mask of the incoming beat
  always_comb begin
    nz_s = '0;
    for (int j = 0; j < N; j++) begin
      nz_s[j] = is_nonzero(in_row[j]);
    end
  end

  assign accept_s    = in_valid && ready_r;
  assign full_s      = (nnz_r == 6'(MAX_NNZ));
  assign valid_s     = (state_r == SCAN) && any_s && !full_s;
  assign hs_s        = valid_s && out_ready;
  assign mask_next_s = mask_r & ~({{(N-1){1'b0}}, 1'b1} << sel_s);
  // a full matrix drops the remaining nonzeros in a single cycle
  assign leave_s     = (state_r == SCAN) && (!any_s || full_s || (hs_s && (mask_next_s == '0)));
  assign row_idx_s   = new_mat_r ? 3'd0 : row_cnt_r;

  assign ent_s.data  = valid_s ? row_r[sel_s] : 8'h00;
  assign ent_s.row   = valid_s ? cur_row_r : 3'd0;
  assign ent_s.col   = valid_s ? sel_s : 3'd0;

  assign in_ready    = ready_r;
  assign out_valid   = valid_s;
  assign out_data    = ent_s.data;
  assign out_row     = ent_s.row;
  assign out_col     = ent_s.col;
  assign nnz         = nnz_r;
  assign overflow    = ovf_r;
  assign mat_done    = leave_s && last_r;

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = accept_s ? SCAN : IDLE;
      SCAN:    state_s = leave_s ? IDLE : SCAN;
      default: state_s = IDLE;
    endcase
  end

  // state, row latch, counters and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ready_r   <= 1'b0;
      mask_r    <= '0;
      row_r     <= '0;
      cur_row_r <= 3'd0;
      row_cnt_r <= 3'd0;
      last_r    <= 1'b0;
      new_mat_r <= 1'b1;
      nnz_r     <= 6'd0;
      ovf_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
      if (accept_s) begin
        mask_r    <= nz_s;
        row_r     <= in_row;
        cur_row_r <= row_idx_s;
        row_cnt_r <= row_idx_s + 3'd1;
        last_r    <= in_last || (row_idx_s == idx_t'(N - 1));
        new_mat_r <= 1'b0;
        if (new_mat_r) begin
          nnz_r <= 6'd0;
          ovf_r <= 1'b0;
        end
      end else if (state_r == SCAN) begin
        if (hs_s) begin
          mask_r <= mask_next_s;
          nnz_r  <= nnz_r + 6'd1;
        end else if (full_s && any_s) begin
          mask_r <= '0;
          ovf_r  <= 1'b1;
        end
        if (leave_s && last_r) begin
          new_mat_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_to_coo_packer.sv
// Scoreboard bench for dense_to_coo_packer: directed cases plus randomized matrices against a reference model.
module tb_dense_to_coo_packer;

  localparam int N    = 8;
  localparam int MAXN = 32;

  typedef struct {
    logic [7:0] d;
    int         r;
    int         c;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0][7:0] in_row;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic [5:0]        nnz;
  logic              overflow;
  logic              mat_done;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  int   m_row = 0, m_nnz = 0, exp_md = 0, md_cnt = 0;
  bit   m_new = 1'b1, m_ovf = 1'b0;
  int   rdy_mode = 0;
  bit   stalled = 1'b0;
  logic [13:0] held;

  dense_to_coo_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .nnz(nnz),
    .overflow(overflow), .mat_done(mat_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  function automatic bit is_nz(input logic [7:0] e);
`ifdef COO_DENORM_FLUSH_EN
    return e[6:3] != 4'd0;
`else
    return e[6:0] != 7'd0;
`endif
  endfunction

  // reference: what one accepted beat contributes to the COO stream
  function automatic void model_beat(input logic [N-1:0][7:0] row, input bit last);
    if (m_new) begin
      m_row = 0; m_nnz = 0; m_ovf = 1'b0; m_new = 1'b0;
    end
    for (int j = 0; j < N; j++) begin
      if (is_nz(row[j])) begin
        if (m_nnz < MAXN) begin
          q.push_back('{d: row[j], r: m_row, c: j});
          m_nnz++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (last || m_row == N - 1) begin
      m_new = 1'b1;
      exp_md++;
    end
    m_row++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // out_ready pattern: 0 always ready, 1 random, 2 stalled
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // monitor: pops the scoreboard on every handshake, checks hold under stall
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (mat_done) md_cnt++;
      if (stalled) begin
        checks++;
        if (!out_valid || {out_data, out_row, out_col} !== held) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h expected held %h", out_valid,
                   {out_data, out_row, out_col}, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        stalled = 1'b0;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_entry: got (%0d,%0d,%h) expected none", out_row, out_col, out_data);
        end else begin
          ent_t e;
          e = q.pop_front();
          if (out_data !== e.d || out_row !== 3'(e.r) || out_col !== 3'(e.c)) begin
            errors++;
            $display("FAIL entry: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                     out_row, out_col, out_data, e.r, e.c, e.d);
          end
        end
      end else if (out_valid) begin
        stalled = 1'b1;
        held    = {out_data, out_row, out_col};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [N-1:0][7:0] row, input bit last);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_row   = row;
      in_last  = last;
      in_valid = 1'b1;
      model_beat(row, last);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(q.size() == 0 && in_ready === 1'b1 && md_cnt == exp_md) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({name, "_drain_q"}, 32'(q.size()), 32'd0);
    chk({name, "_mat_done_cnt"}, 32'(md_cnt), 32'(exp_md));
    chk({name, "_nnz"}, 32'(nnz), 32'(m_nnz));
    chk({name, "_overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    logic [N-1:0][7:0] r;
    int md0;
    rst_n = 1'b0; in_valid = 1'b0; in_row = '0; in_last = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_fields", 32'({out_data, out_row, out_col}), 32'd0);
    chk("rst_nnz", 32'(nnz), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_mat_done", 32'(mat_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // diagonal matrix
    md0 = md_cnt;
    for (int i = 0; i < 4; i++) begin
      r = '0;
      r[i] = 8'h38 + 8'(8 * i);
      send_beat(r, i == 3);
    end
    wait_drain("diag");
    chk("diag_nnz_const", 32'(nnz), 32'd4);
    chk("diag_mat_done_once", 32'(md_cnt - md0), 32'd1);

    // backpressure
    rdy_mode = 2;
    r = '0; r[0] = 8'h38; r[1] = 8'h40; r[2] = 8'h48;
    send_beat(r, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h38);
      chk("bp_col", 32'(out_col), 32'd0);
    end
    rdy_mode = 0;
    wait_drain("bp");
    chk("bp_nnz_const", 32'(nnz), 32'd3);

    // +0 / -0 row
    for (int j = 0; j < N; j++) r[j] = (j % 2 == 0) ? 8'h00 : 8'h80;
    send_beat(r, 1'b1);
    @(negedge clk);
    chk("zero_mat_done", 32'(mat_done), 32'd1);
    chk("zero_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("zero_one_scan", 32'(in_ready), 32'd1);
    wait_drain("zero");
    chk("zero_nnz_const", 32'(nnz), 32'd0);

    // overflow: 40 nonzeros into a 32-entry matrix
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < N; j++) r[j] = 8'h40;
      send_beat(r, i == 4);
    end
    wait_drain("ovf");
    chk("ovf_nnz_const", 32'(nnz), 32'd32);
    chk("ovf_flag_const", 32'(overflow), 32'd1);
    rdy_mode = 0;

    // reset in the middle of row 1
    for (int j = 0; j < N; j++) r[j] = 8'h3C;
    send_beat(r, 1'b0);
    wait_drain("pre_rst");
    rdy_mode = 2;
    r = '0;
    for (int j = 0; j < 5; j++) r[j] = 8'h44;
    send_beat(r, 1'b0);
    @(negedge clk);
    chk("mid_valid_before", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid_in_rst", 32'(out_valid), 32'd0);
    chk("mid_nnz_in_rst", 32'(nnz), 32'd0);
    q.delete();
    m_new = 1'b1; m_nnz = 0; m_ovf = 1'b0; m_row = 0;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    r = '0; r[5] = 8'h50;
    send_beat(r, 1'b1);
    wait_drain("post_rst");

    // denormal element
    r = '0; r[2] = 8'h05;
    send_beat(r, 1'b1);
    wait_drain("denorm");

    // randomized matrices with random backpressure
    rdy_mode = 1;
    for (int m = 0; m < 25; m++) begin
      int rows;
      rows = $urandom_range(1, N);
      for (int i = 0; i < rows; i++) begin
        for (int j = 0; j < N; j++) begin
          if ($urandom_range(0, 2) == 0) r[j] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h80;
          else r[j] = 8'($urandom);
        end
        send_beat(r, i == rows - 1);
      end
      wait_drain("rand");
    end
    rdy_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
